// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Brief    : Shared FSM state encoding and the active-high 7-segment table
//             {G,F,E,D,C,B,A} used by both the decoder and the encoder.
//  Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // Index n holds the lit-segment pattern for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Display-side encoder drawing on the same table as the decoder.
  function automatic logic [6:0] seg7_encode(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture_if
//  Brief    : Raw display lines in, captured digit values and status out.
//             master = display/driver side, slave = capture block.
//  Revision : 1.0 - initial release
// ============================================================================
interface seg7_capture_if;

  logic [6:0] i_Segment;      // active-low segment lines {G..A}
  logic [3:0] i_DIG;          // active-low digit enables
  logic [3:0] o_Digit0;
  logic [3:0] o_Digit1;
  logic [3:0] o_Digit2;
  logic [3:0] o_Digit3;
  logic [3:0] o_Digit_Valid;
  logic       o_Frame_Done;
  logic       o_Error;

  modport master (
    output i_Segment, i_DIG,
    input  o_Digit0, o_Digit1, o_Digit2, o_Digit3,
    input  o_Digit_Valid, o_Frame_Done, o_Error
  );

  modport slave (
    input  i_Segment, i_DIG,
    output o_Digit0, o_Digit1, o_Digit2, o_Digit3,
    output o_Digit_Valid, o_Frame_Done, o_Error
  );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_decode
//  Brief    : Combinational reverse lookup of an active-high segment pattern
//             into its hex value; patterns outside the table are illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       legal
);

  // Search the shared table; entries are unique so at most one matches.
  always_comb begin
    value = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_TABLE[i]) begin
        value = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture
//  Brief    : Samples a multiplexed common-anode 4-digit display, waits for
//             each digit to be stable, decodes it and reports frame/timeout
//             status.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic          i_Clk,
  input  logic          i_Reset,
  seg7_capture_if.slave bus
);

  localparam int               CNT_W      = $clog2(STABLE_CYCLES + 1);
  localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

  logic [6:0]       seg_meta, seg_sync, seg_act;
  logic [3:0]       dig_meta, dig_sync, dig_act;
  logic             selected, same;
  logic [1:0]       index;
  state_t           state, state_next;
  logic             load, inc, capture;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       cur_index;
  logic [6:0]       cur_pattern;
  logic [3:0]       dec_value;
  logic             dec_legal;
  logic [TMO_W-1:0] tmo_cnt;
  logic             timeout_fire;
  logic [3:0]       cap_bit, seen;
  logic             frame_done;
  logic [3:0][3:0]  digit;
  logic [3:0]       valid;
  logic             error;

  // Two-flop synchronizers; raw lines idle high, so reset to all ones.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      seg_meta <= '1;
      seg_sync <= '1;
      dig_meta <= '1;
      dig_sync <= '1;
    end else begin
      seg_meta <= bus.i_Segment;
      seg_sync <= seg_meta;
      dig_meta <= bus.i_DIG;
      dig_sync <= dig_meta;
    end
  end

  assign seg_act = ~seg_sync;
  assign dig_act = ~dig_sync;

  // Exactly one active enable selects a digit; anything else is a gap.
  always_comb begin
    selected = 1'b0;
    index    = 2'd0;
    case (dig_act)
      4'b0001: begin selected = 1'b1; index = 2'd0; end
      4'b0010: begin selected = 1'b1; index = 2'd1; end
      4'b0100: begin selected = 1'b1; index = 2'd2; end
      4'b1000: begin selected = 1'b1; index = 2'd3; end
      default: begin selected = 1'b0; index = 2'd0; end
    endcase
  end

  assign same = (index == cur_index) && (seg_act == cur_pattern);

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // FSM next-state logic; a full count always wins so the capture completes.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (selected) state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt == CNT_STABLE) state_next = ST_HOLD;
        else if (!selected)    state_next = ST_IDLE;
      end
      ST_HOLD: begin
        if (!selected)   state_next = ST_IDLE;
        else if (!same)  state_next = ST_SETTLE;
      end
      default:           state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: counter load/increment and the one-cycle capture strobe.
  always_comb begin
    load    = 1'b0;
    inc     = 1'b0;
    capture = 1'b0;
    case (state)
      ST_IDLE:   load = selected;
      ST_SETTLE: begin
        if (cnt == CNT_STABLE) capture = 1'b1;
        else if (selected) begin
          inc  = same;
          load = !same;
        end
      end
      ST_HOLD:   load = selected && !same;
      default:   load = 1'b0;
    endcase
  end

  // Stability counter plus the index/pattern it is tracking.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      cnt         <= '0;
      cur_index   <= 2'd0;
      cur_pattern <= 7'h00;
    end else if (load) begin
      cnt         <= CNT_ONE;
      cur_index   <= index;
      cur_pattern <= seg_act;
    end else if (inc) begin
      cnt         <= cnt + CNT_ONE;
    end
  end

  seg7_decode u_decode (
    .pattern (cur_pattern),
    .value   (dec_value),
    .legal   (dec_legal)
  );

  // Fires once, on the cycle the idle count reaches its limit.
  assign timeout_fire = !selected && (tmo_cnt == TMO_LAST);

  // Saturating count of cycles without a selected digit.
  always_ff @(posedge i_Clk) begin
    if (i_Reset)                tmo_cnt <= '0;
    else if (selected)          tmo_cnt <= '0;
    else if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + TMO_ONE;
  end

  assign cap_bit    = capture ? (4'b0001 << cur_index) : 4'b0000;
  assign frame_done = (seen == 4'hF);

  // Captured values, validity, sticky error and the per-frame seen mask.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      digit <= '0;
      valid <= 4'h0;
      error <= 1'b0;
      seen  <= 4'h0;
    end else begin
      if (frame_done || timeout_fire) seen <= cap_bit;
      else                            seen <= seen | cap_bit;
      if (timeout_fire) valid <= 4'h0;
      if (capture) begin
        if (dec_legal) begin
          digit[cur_index] <= dec_value;
          valid[cur_index] <= 1'b1;
        end else begin
          valid[cur_index] <= 1'b0;
          error            <= 1'b1;
        end
      end
    end
  end

  assign bus.o_Digit0      = digit[0];
  assign bus.o_Digit1      = digit[1];
  assign bus.o_Digit2      = digit[2];
  assign bus.o_Digit3      = digit[3];
  assign bus.o_Digit_Valid = valid;
  assign bus.o_Frame_Done  = frame_done;
  assign bus.o_Error       = error;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_capture
//  Brief    : Directed self-checking bench for seg7_capture.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_capture;

  localparam int STABLE = 16;
  localparam int TMO    = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   fd_high, fd_rise;
  logic fd_prev;

  seg7_capture_if bus ();

  seg7_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance while tracking o_Frame_Done high cycles and rising edges.
  task automatic tick_mon(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus.o_Frame_Done === 1'b1) begin
        fd_high++;
        if (!fd_prev) fd_rise++;
      end
      fd_prev = (bus.o_Frame_Done === 1'b1);
    end
  endtask

  // Drive raw lines from an active-low enable and an active-high pattern.
  task automatic drive(input logic [3:0] dig, input logic [6:0] pat);
    bus.i_DIG     = dig;
    bus.i_Segment = ~pat;
  endtask

  function automatic logic [15:0] digits();
    return {bus.o_Digit3, bus.o_Digit2, bus.o_Digit1, bus.o_Digit0};
  endfunction

  initial begin
    drive(4'hF, 7'h00);
    rst = 1'b1;
    tick(3);
    check("rst_digits", 32'(digits()), 32'h0);
    check("rst_valid",  32'(bus.o_Digit_Valid), 32'h0);
    check("rst_frame",  32'(bus.o_Frame_Done), 32'h0);
    check("rst_error",  32'(bus.o_Error), 32'h0);
    rst = 1'b0;
    tick(2);

    // Steady "3" on digit 0: capture lands exactly STABLE+3 edges later.
    drive(4'b1110, 7'h4F);
    tick(STABLE + 2);
    check("lat_early_valid", 32'(bus.o_Digit_Valid), 32'h0);
    tick(1);
    check("lat_digit0", 32'(bus.o_Digit0), 32'h3);
    check("lat_valid",  32'(bus.o_Digit_Valid), 32'h1);

    // Scan 1,2,3,4; digit 0 is a recapture and must not complete a frame.
    fd_high = 0;
    fd_rise = 0;
    fd_prev = 1'b0;
    drive(4'b1110, 7'h06); tick_mon(40);
    drive(4'b1101, 7'h5B); tick_mon(40);
    drive(4'b1011, 7'h4F); tick_mon(40);
    drive(4'b0111, 7'h66); tick_mon(40);
    check("scan_digits", 32'(digits()), 32'h4321);
    check("scan_valid",  32'(bus.o_Digit_Valid), 32'hF);
    check("frame_pulses", 32'(fd_rise), 32'd1);
    check("frame_width",  32'(fd_high), 32'd1);

    // Idle gap: valid drops after TMO unselected cycles, values retained.
    drive(4'hF, 7'h00);
    tick(95);
    check("tmo_not_yet", 32'(bus.o_Digit_Valid), 32'hF);
    tick(15);
    check("tmo_valid",  32'(bus.o_Digit_Valid), 32'h0);
    check("tmo_digits", 32'(digits()), 32'h4321);
    check("tmo_error",  32'(bus.o_Error), 32'h0);

    // Pattern changes every 10 cycles on digit 2 never settle.
    for (int k = 0; k < 8; k++) begin
      drive(4'b1011, (k % 2 == 0) ? 7'h06 : 7'h5B);
      tick(10);
    end
    check("toggle_valid",  32'(bus.o_Digit_Valid), 32'h0);
    check("toggle_digit2", 32'(bus.o_Digit2), 32'h3);
    drive(4'hF, 7'h00);
    tick(5);

    // Illegal 0x49 on digit 1, then a legal "4": error stays sticky.
    drive(4'b1101, 7'h49);
    tick(40);
    check("ill_valid",  32'(bus.o_Digit_Valid), 32'h0);
    check("ill_error",  32'(bus.o_Error), 32'h1);
    check("ill_digit1", 32'(bus.o_Digit1), 32'h2);
    drive(4'b1101, 7'h66);
    tick(40);
    check("rec_digit1", 32'(bus.o_Digit1), 32'h4);
    check("rec_valid",  32'(bus.o_Digit_Valid), 32'h2);
    check("rec_error",  32'(bus.o_Error), 32'h1);

    // Reset while the stability count sits at STABLE-1.
    drive(4'b1110, 7'h6D);
    tick(STABLE + 1);
    rst = 1'b1;
    drive(4'hF, 7'h00);
    tick(1);
    check("mid_rst_digits", 32'(digits()), 32'h0);
    check("mid_rst_valid",  32'(bus.o_Digit_Valid), 32'h0);
    check("mid_rst_frame",  32'(bus.o_Frame_Done), 32'h0);
    check("mid_rst_error",  32'(bus.o_Error), 32'h0);
    rst = 1'b0;
    tick(25);
    check("post_rst_valid",  32'(bus.o_Digit_Valid), 32'h0);
    check("post_rst_digits", 32'(digits()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive identical sampled cycles required before a digit is captured.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000: cycles with no digit strobe before all captured digits are invalidated.
REQ-003 i_Clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 i_Reset  input  1  reset, synchronous and active-high.
REQ-005 i_Segment  input  7  segment lines {G,F,E,D,C,B,A}, active-low (common-anode), asynchronous to i_Clk.
REQ-006 i_DIG  input  4  digit enables, active-low, one-hot-low when a digit is being driven, asynchronous to i_Clk.
REQ-007 o_Digit0..o_Digit3  output  4 each  last captured hex value per digit position.
REQ-008 o_Digit_Valid  output  4  bit n high when o_Digitn holds a legally decoded value.
REQ-009 o_Frame_Done  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-010 o_Error  output  1  sticky flag: an illegal segment pattern was captured.

Function
REQ-011 i_Segment and i_DIG SHALL pass through a 2-flop synchronizer; all decisions SHALL use synchronized values, inverted to active-high.
REQ-012 A sample is "selected" when exactly one synchronized DIG bit is active; zero or multiple active bits are "unselected".
REQ-013 FSM states: IDLE, SETTLE, HOLD.
REQ-014 IDLE: on a selected sample, load the stability counter with 1, record digit index and pattern, go to SETTLE.
REQ-015 SETTLE: same index and same pattern increments the counter; any change of index or pattern reloads the counter with 1 and records the new values; unselected returns to IDLE.
REQ-016 SETTLE: when the counter reaches STABLE_CYCLES, capture on that cycle and go to HOLD.
REQ-017 Capture: decode the pattern via the shared table (0-F); legal -> write o_Digitn, set o_Digit_Valid[n]; illegal (including blank 0x00) -> leave o_Digitn unchanged, clear o_Digit_Valid[n], set o_Error.
REQ-018 HOLD: no further capture; any change of index or pattern reloads the counter with 1 and returns to SETTLE; unselected returns to IDLE.
REQ-019 Outputs update one cycle after the capture cycle; capture latency from the first stable synchronized sample = STABLE_CYCLES+1 cycles (+2 synchronizer).
REQ-020 A 4-bit seen mask SHALL set bit n on every capture (legal or illegal); when the mask becomes 1111, pulse o_Frame_Done for one cycle and clear the mask in the same cycle; a capture on that same cycle sets its bit in the cleared mask.
REQ-021 Timeout counter increments every cycle without a selected sample, clears on any selected sample, and saturates; on reaching TIMEOUT_CYCLES, clear o_Digit_Valid and the seen mask; o_Digitn values and o_Error are retained.
REQ-022 Recapture of an already-seen position before the frame completes SHALL overwrite its value and SHALL NOT pulse o_Frame_Done.
REQ-023 o_Error SHALL clear only on reset.

Reset
REQ-024 On i_Reset high at a clock edge: FSM = IDLE, synchronizers = inactive (all ones raw), counters = 0, seen mask = 0, o_Digit0..3 = 0, o_Digit_Valid = 0, o_Frame_Done = 0, o_Error = 0.
REQ-025 Reset mid-SETTLE SHALL abandon the pending capture with no output change other than the reset values.

Structure
REQ-026 Package seg7_pkg SHALL hold the FSM state enum and the 16-entry active-high segment table {G..A}: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 for 0-F; the display encoder SHALL use the same table.
REQ-027 One sub-module, seg7_decode (combinational: pattern -> value + legal flag), is natural; synchronizer and FSM stay in seg7_capture.

Verification
REQ-028 Drive DIG=1110, Segment=~0x4F steadily -> o_Digit0=3, Valid[0]=1 exactly STABLE_CYCLES+3 cycles after stimulus; no capture earlier.
REQ-029 Scan digits 0-3 with 1,2,3,4 at 40 cycles each -> values 1,2,3,4, Valid=1111, o_Frame_Done pulses once, width 1 cycle.
REQ-030 Toggle segments every 10 cycles (< STABLE_CYCLES) on digit 2 -> no capture, Valid[2] stays 0.
REQ-031 Hold pattern 0x49 on digit 1 -> Valid[1]=0, o_Error=1 and remains 1 after legal captures until reset.
REQ-032 Capture all digits, then DIG=1111 for TIMEOUT_CYCLES (override 100) -> Valid=0000, digit values retained.
REQ-033 Assert i_Reset at counter = STABLE_CYCLES-1 -> no capture, all outputs at reset values next cycle.
